alu_control_unit: RTL

Moore-style control sequencer driving the 32-bit single-bus datapath: issues every register, bus-driver, ALU and memory strobe for instruction fetch and for register-register ALU, unary, multiply/divide, nop and halt instructions. Sits between the memory interface and the datapath. Reads the instruction register contents back from the datapath. Replaces hand-sequenced control strobes in datapath benches.

---
 rtl/alu_control_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - Moore control sequencer for the 32-bit single-bus datapath
// Optional feature macro: CU_MULDIV_EN enables the mul/div sequence (T3-T6).
module alu_control_unit #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                Clock,
  input  logic                clr,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                PCin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                MARin,
  output logic                MDRin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [4:0]          ALU_select,
  output logic                run,
  output logic                illegal_op
);

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
`ifdef CU_MULDIV_EN
    T6,
`endif
    HALT
  } state_t;

  state_t state, state_next;
  logic   t1_entry;
  logic   armed;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_binary, is_unary, is_muldiv, is_nop, is_halt;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_binary = (opcode[4:3] == 2'b00);
  assign is_unary  = (opcode == 5'b01000) || (opcode == 5'b01001);
`ifdef CU_MULDIV_EN
  assign is_muldiv = (opcode == 5'b01010) || (opcode == 5'b01011);
`else
  assign is_muldiv = 1'b0;
`endif
  assign is_nop    = (opcode == 5'b11010);
  assign is_halt   = (opcode == 5'b11011);

  // Indices beyond the register file select nothing.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ({28'd0, idx} == i) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  // armed keeps the first edge after reset release in IDLE; t1_entry marks the first T1 cycle.
  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      t1_entry <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_next;
      t1_entry <= (state == T0);
      armed    <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    Rout       = '0;
    Rin        = '0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    ALU_select = 5'd0;
    illegal_op = 1'b0;
    run        = (state != IDLE) && (state != HALT);

    case (state)
      IDLE: begin
        if (start && armed) state_next = T0;
      end
      T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        state_next = T1;
      end
      T1: begin
        Zlowout = t1_entry;
        PCin    = t1_entry;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_next = T2;
      end
      T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        state_next = T3;
      end
      T3: begin
        if (is_binary || is_unary) begin
          Rout       = reg_sel(rb);
          Yin        = 1'b1;
          state_next = T4;
        end else if (is_muldiv) begin
          Rout       = reg_sel(ra);
          Yin        = 1'b1;
          state_next = T4;
        end else if (is_halt) begin
          state_next = HALT;
        end else begin
          illegal_op = !is_nop;
          state_next = T0;
        end
      end
      T4: begin
        Zin        = 1'b1;
        ALU_select = opcode;
        Rout       = is_binary ? reg_sel(rc) : reg_sel(rb);
        state_next = T5;
      end
      T5: begin
        Zlowout    = 1'b1;
        state_next = T0;
`ifdef CU_MULDIV_EN
        if (is_muldiv) begin
          LOin       = 1'b1;
          state_next = T6;
        end else begin
          Rin = reg_sel(ra);
        end
`else
        Rin = reg_sel(ra);
`endif
      end
`ifdef CU_MULDIV_EN
      T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        state_next = T0;
      end
`endif
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
